// File: rtl/ntt_mod_reduce.sv
// ntt_mod_reduce: reduces the NTT butterfly sum/difference pair modulo Val_Q.
// Four register layers (three pipeline stages plus the output register) give a
// fixed 3-cycle latency from acceptance to valid_o.  Reduction is Barrett with
// k = 2*DATA_WIDTH applied to |x|, followed by a sign correction, so any
// two's-complement input in range maps into [0, Val_Q) without overflow.
module ntt_mod_reduce #(
    parameter int              DATA_WIDTH = 32,
    parameter longint unsigned Val_Q      = 8380417
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [2*DATA_WIDTH-1:0]   sum_i,
    input  logic [2*DATA_WIDTH-1:0]   diff_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [DATA_WIDTH-1:0]     res1_o,
    output logic [DATA_WIDTH-1:0]     res2_o,
    output logic                      valid_o,
    input  logic                      ready_i
);

    localparam int W2 = 2 * DATA_WIDTH;
    localparam int W4 = 4 * DATA_WIDTH;

    localparam logic [W2:0]           Q_EXT = (W2 + 1)'(Val_Q);
    localparam logic [W2-1:0]         Q_W2  = W2'(Val_Q);
    localparam logic [DATA_WIDTH:0]   Q_R   = (DATA_WIDTH + 1)'(Val_Q);
    localparam logic [DATA_WIDTH:0]   Q2_R  = (DATA_WIDTH + 1)'(2 * Val_Q);
    localparam logic [DATA_WIDTH-1:0] Q_D   = DATA_WIDTH'(Val_Q);

    // Elaboration-time long division giving floor(2^W2 / Val_Q); it only
    // produces a constant and never becomes hardware.
    function automatic logic [W2-1:0] barrett_const();
        logic [W2:0] rem;
        logic [W2:0] quo;
        logic        ge;
        rem = '0;
        quo = '0;
        for (int i = W2; i >= 0; i--) begin
            rem = {rem[W2-1:0], (i == W2)};
            ge  = (rem >= Q_EXT);
            if (ge) begin
                rem = rem - Q_EXT;
            end
            quo = {quo[W2-1:0], ge};
        end
        return quo[W2-1:0];
    endfunction

    localparam logic [W2-1:0] BARRETT_M = barrett_const();

    // Magnitude of a signed input; -2^(W2-1) maps to 2^(W2-1), still exact.
    function automatic logic [W2-1:0] abs_val(input logic signed [W2-1:0] x);
        return x[W2-1] ? (~$unsigned(x) + 1'b1) : $unsigned(x);
    endfunction

    // Barrett quotient estimate: floor(a*M / 2^W2), at most 2 below a/Q.
    function automatic logic [W2-1:0] barrett_quot(input logic [W2-1:0] a);
        return W2'(({{W2{1'b0}}, a} * {{W2{1'b0}}, BARRETT_M}) >> W2);
    endfunction

    // Remainder a - q*Q is exact and below 3*Q, so DATA_WIDTH+1 bits hold it.
    function automatic logic [DATA_WIDTH:0] barrett_rem(input logic [W2-1:0] a,
                                                        input logic [W2-1:0] q);
        return (DATA_WIDTH + 1)'(a - q * Q_W2);
    endfunction

    // Bring a value in [0, 3*Q) into [0, Q).
    function automatic logic [DATA_WIDTH-1:0] fold_sub(input logic [DATA_WIDTH:0] r);
        return (r >= Q2_R) ? DATA_WIDTH'(r - Q2_R) :
               (r >= Q_R)  ? DATA_WIDTH'(r - Q_R)  : DATA_WIDTH'(r);
    endfunction

    // |x| mod Q -> x mod Q for negative x, keeping zero at zero.
    function automatic logic [DATA_WIDTH-1:0] sign_fix(input logic neg,
                                                       input logic [DATA_WIDTH-1:0] r);
        return (neg && (r != '0)) ? (Q_D - r) : r;
    endfunction

    logic signed [W2-1:0] sum_s;
    logic signed [W2-1:0] diff_s;
    logic                 en;

    logic                  vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic                  neg1_p0_q, neg1_p0_d, neg2_p0_q, neg2_p0_d;
    logic [W2-1:0]         abs1_p0_q, abs1_p0_d, abs2_p0_q, abs2_p0_d;
    logic                  neg1_p1_q, neg1_p1_d, neg2_p1_q, neg2_p1_d;
    logic [W2-1:0]         abs1_p1_q, abs1_p1_d, abs2_p1_q, abs2_p1_d;
    logic [W2-1:0]         qest1_p1_q, qest1_p1_d, qest2_p1_q, qest2_p1_d;
    logic                  neg1_p2_q, neg1_p2_d, neg2_p2_q, neg2_p2_d;
    logic [DATA_WIDTH-1:0] rem1_p2_q, rem1_p2_d, rem2_p2_q, rem2_p2_d;
    logic                  valid_o_q, valid_o_d;
    logic [DATA_WIDTH-1:0] res1_q, res1_d, res2_q, res2_d;

    assign sum_s   = sum_i;
    assign diff_s  = diff_i;
    assign ready_o = en;
    assign valid_o = valid_o_q;
    assign res1_o  = res1_q;
    assign res2_o  = res2_q;

    // Next-state for every stage: hold by default, shift all stages when en.
    always_comb begin
        en         = ready_i || !valid_o_q;
        vld_p0_d   = vld_p0_q;
        neg1_p0_d  = neg1_p0_q;
        neg2_p0_d  = neg2_p0_q;
        abs1_p0_d  = abs1_p0_q;
        abs2_p0_d  = abs2_p0_q;
        vld_p1_d   = vld_p1_q;
        neg1_p1_d  = neg1_p1_q;
        neg2_p1_d  = neg2_p1_q;
        abs1_p1_d  = abs1_p1_q;
        abs2_p1_d  = abs2_p1_q;
        qest1_p1_d = qest1_p1_q;
        qest2_p1_d = qest2_p1_q;
        vld_p2_d   = vld_p2_q;
        neg1_p2_d  = neg1_p2_q;
        neg2_p2_d  = neg2_p2_q;
        rem1_p2_d  = rem1_p2_q;
        rem2_p2_d  = rem2_p2_q;
        valid_o_d  = valid_o_q;
        res1_d     = res1_q;
        res2_d     = res2_q;
        if (en) begin
            // p0: sign and magnitude
            vld_p0_d   = valid_i;
            neg1_p0_d  = (sum_s < 0);
            neg2_p0_d  = (diff_s < 0);
            abs1_p0_d  = abs_val(sum_s);
            abs2_p0_d  = abs_val(diff_s);
            // p1: Barrett quotient estimate
            vld_p1_d   = vld_p0_q;
            neg1_p1_d  = neg1_p0_q;
            neg2_p1_d  = neg2_p0_q;
            abs1_p1_d  = abs1_p0_q;
            abs2_p1_d  = abs2_p0_q;
            qest1_p1_d = barrett_quot(abs1_p0_q);
            qest2_p1_d = barrett_quot(abs2_p0_q);
            // p2: remainder folded into [0, Q)
            vld_p2_d   = vld_p1_q;
            neg1_p2_d  = neg1_p1_q;
            neg2_p2_d  = neg2_p1_q;
            rem1_p2_d  = fold_sub(barrett_rem(abs1_p1_q, qest1_p1_q));
            rem2_p2_d  = fold_sub(barrett_rem(abs2_p1_q, qest2_p1_q));
            // output: sign correction
            valid_o_d  = vld_p2_q;
            res1_d     = sign_fix(neg1_p2_q, rem1_p2_q);
            res2_d     = sign_fix(neg2_p2_q, rem2_p2_q);
        end
    end

    // Control and output registers; reset clears all valids and the results.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            valid_o_q <= 1'b0;
            res1_q    <= '0;
            res2_q    <= '0;
        end else begin
            vld_p0_q  <= vld_p0_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            valid_o_q <= valid_o_d;
            res1_q    <= res1_d;
            res2_q    <= res2_d;
        end
    end

    // Datapath stage registers; contents are qualified by the valid bits.
    always_ff @(posedge clk_i) begin
        neg1_p0_q  <= neg1_p0_d;
        neg2_p0_q  <= neg2_p0_d;
        abs1_p0_q  <= abs1_p0_d;
        abs2_p0_q  <= abs2_p0_d;
        neg1_p1_q  <= neg1_p1_d;
        neg2_p1_q  <= neg2_p1_d;
        abs1_p1_q  <= abs1_p1_d;
        abs2_p1_q  <= abs2_p1_d;
        qest1_p1_q <= qest1_p1_d;
        qest2_p1_q <= qest2_p1_d;
        neg1_p2_q  <= neg1_p2_d;
        neg2_p2_q  <= neg2_p2_d;
        rem1_p2_q  <= rem1_p2_d;
        rem2_p2_q  <= rem2_p2_d;
    end

endmodule

// File: tb/tb_ntt_mod_reduce.sv
// Bench for ntt_mod_reduce: table-driven vectors and hand sequences feed a
// scoreboard queue; results are compared as they leave the block.
module tb_ntt_mod_reduce;

    localparam int     DW = 32;
    localparam longint Q  = 8380417;

    logic               clk_i = 1'b0;
    logic               reset_ni;
    logic [2*DW-1:0]    sum_i;
    logic [2*DW-1:0]    diff_i;
    logic               valid_i;
    logic               ready_o;
    logic [DW-1:0]      res1_o;
    logic [DW-1:0]      res2_o;
    logic               valid_o;
    logic               ready_i;

    always #5 clk_i = ~clk_i;

    ntt_mod_reduce #(.DATA_WIDTH(DW), .Val_Q(64'd8380417)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .sum_i    (sum_i),
        .diff_i   (diff_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .res1_o   (res1_o),
        .res2_o   (res2_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    typedef struct {
        longint e1;
        longint e2;
    } exp_t;

    typedef struct {
        longint s;
        longint d;
        longint e1;
        longint e2;
        bit     model;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    exp_t       mon_e;
    longint     exp1_drv;
    longint     exp2_drv;
    bit         acc;
    bit         prev_stall = 1'b0;
    logic [DW-1:0] prev_r1;
    logic [DW-1:0] prev_r2;
    vec_t       tab[12];

    function automatic longint gold(input longint x);
        longint r;
        r = x % Q;
        if (r < 0) r = r + Q;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic drive(input longint s, input longint d, input longint e1, input longint e2);
        sum_i    = s;
        diff_i   = d;
        exp1_drv = e1;
        exp2_drv = e2;
        valid_i  = 1'b1;
    endtask

    task automatic drive_gold(input longint s, input longint d);
        drive(s, d, gold(s), gold(d));
    endtask

    // One clock: note whether the pair on the inputs is taken, then move past the edge.
    task automatic step();
        @(negedge clk_i);
        acc = valid_i && ready_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (reset_ni !== 1'b1) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid_o", valid_o, 1);
                chk("hold_res1", res1_o, prev_r1);
                chk("hold_res2", res2_o, prev_r2);
            end
            if (valid_o && !ready_i) chk("ready_o_stall", ready_o, 0);
            if (valid_o && ready_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got res1=%0d res2=%0d required no output", res1_o, res2_o);
                end else begin
                    mon_e = sb.pop_front();
                    chk("res1", res1_o, mon_e.e1);
                    chk("res2", res2_o, mon_e.e2);
                end
            end
            if (valid_i && ready_o) sb.push_back('{exp1_drv, exp2_drv});
            prev_stall = valid_o && !ready_i;
            prev_r1    = res1_o;
            prev_r2    = res2_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_ready_low;
        int k;

        tab[0]  = '{8380418, -1, 1, 8380416, 1'b0};
        tab[1]  = '{Q * Q + 5, -Q, 5, 0, 1'b0};
        tab[2]  = '{0, 0, 0, 0, 1'b0};
        tab[3]  = '{Q - 1, -(Q - 1), Q - 1, 1, 1'b0};
        tab[4]  = '{2 * Q + 7, -2 * Q - 7, 7, Q - 7, 1'b0};
        tab[5]  = '{Q, -Q - 1, 0, Q - 1, 1'b0};
        tab[6]  = '{-5, 12345, Q - 5, 12345, 1'b0};
        tab[7]  = '{1000 * Q + 3, -(1000 * Q + 3), 3, Q - 3, 1'b0};
        tab[8]  = '{100 * Q * Q + 17, -(100 * Q * Q + 17), 17, Q - 17, 1'b0};
        tab[9]  = '{64'sh7FFF_FFFF_FFFF_FFFF, 64'sh8000_0000_0000_0000, 0, 0, 1'b1};
        tab[10] = '{64'sh4000_0000_0000_0000, -64'sh4000_0000_0000_0000, 0, 0, 1'b1};
        tab[11] = '{64'sh7FFF_FFFF_0000_0001, -64'sh0000_0001_2345_6789, 0, 0, 1'b1};

        // Reset held two cycles with valid_i high
        reset_ni = 1'b0;
        ready_i  = 1'b1;
        drive(8380418, -1, 1, 8380416);
        step();
        step();
        chk("rst_res1", res1_o, 0);
        chk("rst_res2", res2_o, 0);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_ready_o", ready_o, 1);

        // Single pair right after reset: exactly 3 cycles to valid_o, for one cycle
        reset_ni = 1'b1;
        drive(8380418, -1, 1, 8380416);
        step();
        valid_i = 1'b0;
        step();
        chk("lat_edge1_valid_o", valid_o, 0);
        step();
        chk("lat_edge2_valid_o", valid_o, 0);
        step();
        chk("lat_edge3_valid_o", valid_o, 1);
        step();
        chk("lat_edge4_valid_o", valid_o, 0);

        // Table vectors back-to-back at full throughput
        ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (tab[i].model) drive_gold(tab[i].s, tab[i].d);
            else drive(tab[i].s, tab[i].d, tab[i].e1, tab[i].e2);
            step();
            chk("tab_accept", acc, 1);
        end
        drain("tab_drain");

        // Backpressure: six pairs, ready_i low for relative cycles 4..9
        k = 1;
        saw_ready_low = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            ready_i = !(c >= 4 && c <= 9);
            if (k <= 6) drive(k, -k, k, Q - k);
            else valid_i = 1'b0;
            #1;
            if (valid_o && !ready_o) saw_ready_low = 1'b1;
            step();
            if (acc) k++;
        end
        chk("bp_all_accepted", k, 7);
        chk("bp_ready_fell", saw_ready_low, 1);
        drain("bp_drain");

        // Reset while three pairs are in flight
        ready_i = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            drive_gold(j * 1001, -j * 77);
            step();
        end
        valid_i  = 1'b0;
        reset_ni = 1'b0;
        step();
        chk("mrst_valid_o", valid_o, 0);
        chk("mrst_ready_o", ready_o, 1);
        reset_ni = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            chk("mrst_no_stale", valid_o, 0);
        end

        // Random traffic with random valid and ready patterns
        for (int i = 0; i < 300; i++) begin
            longint s;
            longint d;
            ready_i = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: begin
                    s = {$urandom, $urandom};
                    d = {$urandom, $urandom};
                end
                1: begin
                    s = longint'($urandom_range(0, 2000)) - 1000;
                    d = -longint'($urandom_range(0, 3000));
                end
                default: begin
                    s = Q * longint'($urandom_range(0, 100000)) + longint'($urandom_range(0, 2)) - 1;
                    d = -(Q * longint'($urandom_range(0, 100000))) - longint'($urandom_range(0, 2)) + 1;
                end
            endcase
            if ($urandom_range(0, 3) != 0) drive_gold(s, d);
            else valid_i = 1'b0;
            step();
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_mod_reduce.md
NTT_MOD_REDUCE -- requirements
Module: ntt_mod_reduce

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the width of one reduced coefficient.
REQ-002 The block SHALL have parameter Val_Q, default 8380417, the odd prime modulus, with Val_Q < 2^(DATA_WIDTH-1).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_ni, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port sum_i, input, 2*DATA_WIDTH bits: the butterfly sum output (u+t), two's-complement signed.
REQ-006 The block SHALL have port diff_i, input, 2*DATA_WIDTH bits: the butterfly difference output (u-t), two's-complement signed, possibly negative.
REQ-007 The block SHALL have port valid_i, input, 1 bit: sum_i/diff_i hold a pair.
REQ-008 The block SHALL have port ready_o, output, 1 bit: the block accepts the pair this cycle.
REQ-009 The block SHALL have port res1_o, output, DATA_WIDTH bits: sum_i reduced into [0, Val_Q).
REQ-010 The block SHALL have port res2_o, output, DATA_WIDTH bits: diff_i reduced into [0, Val_Q).
REQ-011 The block SHALL have port valid_o, output, 1 bit: res1_o/res2_o hold a result.
REQ-012 The block SHALL have port ready_i, input, 1 bit: downstream accepts the result this cycle.

Function
REQ-013 A transfer SHALL occur on the input side when valid_i && ready_o, and on the output side when valid_o && ready_i, both sampled at the rising edge.
REQ-014 The block SHALL be a 3-stage pipeline with a fixed latency of 3 cycles: a pair accepted at edge n SHALL appear on the outputs with valid_o=1 after edge n+3, provided no stall occurs.
REQ-015 Advance enable: en = ready_i || !valid_o.
- ready_o SHALL equal en, combinationally.
- All stages, including their valid bits, SHALL shift only when en=1; when en=0 every stage holds.
- Bubbles are not collapsed.
REQ-016 When en=1 and valid_i=0, a bubble (valid=0) SHALL enter stage 1.
REQ-017 res1_o SHALL equal the mathematical value of signed sum_i mod Val_Q, in [0, Val_Q); res2_o SHALL be the same for diff_i.
- Required for all inputs in [-2^(2*DATA_WIDTH-1), 2^(2*DATA_WIDTH-1)).
- Negative inputs SHALL map to the non-negative representative, e.g. -1 -> Val_Q-1.
REQ-018 The reduction method (Barrett or folded subtraction) is free, but no internal intermediate SHALL overflow for any input in range, and no divider or modulo operator SHALL be inferred.
REQ-019 The two lanes SHALL be processed in lockstep; res1_o and res2_o always belong to the same accepted pair.
REQ-020 Order SHALL be preserved, with no loss or duplication, under any pattern of valid_i and ready_i.
REQ-021 While valid_o=1 and ready_i=0, res1_o, res2_o and valid_o SHALL remain stable.
REQ-022 Simultaneous input and output transfer in one cycle SHALL be supported at full throughput (one pair per cycle).

Reset
REQ-023 When reset_ni=0 at a rising edge, all stage valid bits, valid_o, res1_o and res2_o SHALL become 0 after that edge, regardless of en.
REQ-024 During reset, ready_o SHALL read 1, since valid_o=0.
REQ-025 Any pair in flight when reset asserts SHALL be discarded and never emerge.
REQ-026 After reset deasserts, the first accepted pair SHALL emerge exactly 3 cycles later.

Verification
REQ-027 Reset scenario: hold reset_ni=0 for 2 cycles with valid_i=1 -> res1_o=0, res2_o=0, valid_o=0, ready_o=1.
REQ-028 Basic scenario: sum_i=8380418, diff_i=-1 (all ones), valid_i=1 for 1 cycle, ready_i=1 -> 3 cycles later valid_o=1 for exactly 1 cycle with res1_o=1 and res2_o=8380416.
REQ-029 Boundary scenario: sum_i=Val_Q*Val_Q+5, diff_i=-Val_Q -> res1_o=5, res2_o=0.
REQ-030 Boundary scenario: sum_i=2^63-1, diff_i=-2^63 -> outputs match a golden model, both in [0, Val_Q).
REQ-031 Backpressure scenario: stream 6 pairs with sum_i=k and diff_i=-k for k=1..6, and hold ready_i=0 from cycle 4 to cycle 9.
- ready_o SHALL fall while valid_o=1 and ready_i=0.
- Outputs SHALL be held stable during the stall.
- All 6 results SHALL then emerge in order: res1_o=k, res2_o=Val_Q-k.
REQ-032 Reset mid-stream scenario: assert reset_ni=0 for 1 cycle while 3 pairs are in flight -> valid_o=0 after that edge, and no stale result ever appears.
